// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared screen geometry, colours, segment word layout and
//               render FSM state encoding for the snake renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int MAX_LEN  = 2047;

    localparam int LEN_W = 11;
    localparam int SEG_W = 17;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

    localparam logic [COL_W-1:0] HEAD_COLOUR = 3'b010;
    localparam logic [COL_W-1:0] BODY_COLOUR = 3'b110;
    localparam logic [COL_W-1:0] BG_COLOUR   = 3'b000;

    localparam int TYPE_HI = 16;
    localparam int TYPE_LO = 15;
    localparam int X_HI    = 14;
    localparam int X_LO    = 7;
    localparam int Y_HI    = 6;
    localparam int Y_LO    = 0;

    localparam logic [1:0] SEG_BODY = 2'b00;
    localparam logic [1:0] SEG_HEAD = 2'b01;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ERASE   = 3'd2,
        ST_REQ     = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_PLOT    = 3'd5,
        ST_FINISH  = 3'd6
    } state_e;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (int'(l) > MAX_LEN) return LEN_W'(MAX_LEN);
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : snake_renderer_if
// Description : Control, segment-RAM read port and VGA-adapter write bus of
//               the snake renderer.
// Revision    : 1.0 - initial release
// ============================================================================
interface snake_renderer_if;
    import snake_pkg::*;

    logic             start;
    logic [LEN_W-1:0] length;
    logic             ram_gnt;
    logic [SEG_W-1:0] ram_q;
    logic             ram_req;
    logic [LEN_W-1:0] ram_addr;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [COL_W-1:0] vga_colour;
    logic             vga_plot;
    logic             busy;
    logic             done;
    logic             oob;

    modport master (
        input  start, length, ram_gnt, ram_q,
        output ram_req, ram_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, oob
    );

    modport slave (
        output start, length, ram_gnt, ram_q,
        input  ram_req, ram_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, oob
    );

endinterface
`default_nettype wire

// File: rtl/snake_renderer_screen_sweep.sv
`default_nettype none
// ============================================================================
// Module      : screen_sweep
// Description : Full-screen raster counter, x fastest, with a last-pixel flag.
// Revision    : 1.0 - initial release
// ============================================================================
module screen_sweep
    import snake_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           x_end;

    assign x_end  = (x_q == X_W'(SCREEN_W - 1));
    assign last_o = x_end && (y_q == Y_W'(SCREEN_H - 1));
    assign x_o    = x_q;
    assign y_o    = y_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en_i) begin
            x_q <= x_end  ? '0 : x_q + 1'b1;
            if (x_end) begin
                y_q <= last_o ? '0 : y_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_renderer.sv
`default_nettype none
// ============================================================================
// Module      : snake_renderer
// Description : Reads snake segments from the shared RAM and turns them into
//               VGA-adapter pixel writes; clears the screen after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_renderer
    import snake_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    snake_renderer_if.master bus
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d, len_q, len_d;
    logic [X_W-1:0]   tx_q, tx_d, vga_x_q, vga_x_d;
    logic [Y_W-1:0]   ty_q, ty_d, vga_y_q, vga_y_d;
    logic [COL_W-1:0] vga_col_q, vga_col_d;
    logic             tail_valid_q, tail_valid_d;
    logic             oob_q, oob_d, plot_q, plot_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             sweep_en, sweep_last;
    logic [X_W-1:0]   sweep_x;
    logic [Y_W-1:0]   sweep_y;

    logic [1:0]       seg_type;
    logic [X_W-1:0]   seg_x;
    logic [Y_W-1:0]   seg_y;
    logic             seg_onscreen, seg_drawable, seg_last;

    screen_sweep u_sweep (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (sweep_en),
        .x_o     (sweep_x),
        .y_o     (sweep_y),
        .last_o  (sweep_last)
    );

    assign seg_type     = bus.ram_q[TYPE_HI:TYPE_LO];
    assign seg_x        = bus.ram_q[X_HI:X_LO];
    assign seg_y        = bus.ram_q[Y_HI:Y_LO];
    assign seg_onscreen = (seg_x < X_W'(SCREEN_W)) && (seg_y < Y_W'(SCREEN_H));
    assign seg_drawable = !seg_type[1] && seg_onscreen;
    // Only reached in PLOT, where len_q is known to be non-zero.
    assign seg_last     = (idx_q == len_q - 1'b1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        tx_d         = tx_q;
        ty_d         = ty_q;
        tail_valid_d = tail_valid_q;
        oob_d        = oob_q;
        plot_d       = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_col_d    = vga_col_q;
        sweep_en     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                sweep_en  = 1'b1;
                plot_d    = 1'b1;
                vga_x_d   = sweep_x;
                vga_y_d   = sweep_y;
                vga_col_d = BG_COLOUR;
                if (sweep_last) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.start) begin
                    len_d   = clamp_len(bus.length);
                    idx_d   = '0;
                    oob_d   = 1'b0;
                    state_d = ST_ERASE;
                end
            end
            ST_ERASE: begin
                plot_d    = tail_valid_q;
                vga_x_d   = tx_q;
                vga_y_d   = ty_q;
                vga_col_d = BG_COLOUR;
                state_d   = ST_REQ;
            end
            ST_REQ: begin
                if (len_q == '0)     state_d = ST_FINISH;
                else if (bus.ram_gnt) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: state_d = ST_PLOT;
            ST_PLOT: begin
                plot_d    = seg_drawable;
                vga_x_d   = seg_x;
                vga_y_d   = seg_y;
                vga_col_d = (seg_type == SEG_HEAD) ? HEAD_COLOUR : BODY_COLOUR;
                if (!seg_onscreen) oob_d = 1'b1;
                if (seg_last) begin
                    tx_d         = seg_x;
                    ty_d         = seg_y;
                    tail_valid_d = seg_drawable;
                    state_d      = ST_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_CLEAR;
        endcase
        // busy stays up through the cycle that shows the final clear pixel.
        busy_d = ((state_d != ST_IDLE) && (state_d != ST_FINISH)) || (state_q == ST_CLEAR);
        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            idx_q        <= '0;
            len_q        <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            tail_valid_q <= 1'b0;
            oob_q        <= 1'b0;
            plot_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_col_q    <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            tx_q         <= tx_d;
            ty_q         <= ty_d;
            tail_valid_q <= tail_valid_d;
            oob_q        <= oob_d;
            plot_q       <= plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_col_q    <= vga_col_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.ram_req    = ((state_q == ST_REQ) && (len_q != '0)) ||
                            (state_q == ST_RD_WAIT) || (state_q == ST_PLOT);
    assign bus.ram_addr   = idx_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_col_q;
    assign bus.vga_plot   = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.oob        = oob_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_renderer
// Description : Directed self-checking bench for snake_renderer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_renderer;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         cyc;
    } plot_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   t0;
    plot_t plots[$];
    logic [16:0] mem [0:2047];

    snake_renderer_if bus ();

    snake_renderer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

    always @(negedge clk) begin
        if (bus.vga_plot === 1'b1) plots.push_back('{bus.vga_x, bus.vga_y, bus.vga_colour, cyc});
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_plot(input string tag, input int i, input logic [7:0] x,
                              input logic [6:0] y, input logic [2:0] c);
        logic [31:0] obs;
        obs = '1;
        if (i < plots.size()) obs = {14'd0, plots[i].x, plots[i].y, plots[i].c};
        check(tag, obs, {14'd0, x, y, c});
    endtask

    task automatic start_pass(input logic [10:0] l, output int t);
        plots.delete();
        bus.length = l;
        bus.start  = 1'b1;
        t = cyc;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", {31'd0, bus.done}, 1);
        tick();
    endtask

    // Called in the cycle right after reset was sampled low.
    task automatic check_clear();
        int n = 0;
        int bad = 0;
        plots.delete();
        done_cnt = 0;
        while (bus.busy !== 1'b0 && n < 20010) begin
            tick();
            n++;
        end
        check("clear_busy_falls", {31'd0, bus.busy}, 0);
        foreach (plots[i]) if (plots[i].c != 3'd0) bad++;
        check("clear_count", plots.size(), 19200);
        check("clear_bg_colour", bad, 0);
        check_plot("clear_first", 0, 8'd0, 7'd0, 3'd0);
        check_plot("clear_last", plots.size() - 1, 8'd159, 7'd119, 3'd0);
        if (plots.size() > 0) check("clear_busy_lag", cyc - plots[$].cyc, 1);
        else                  check("clear_busy_lag", 0, 1);
        check("clear_no_done", done_cnt, 0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.length  = '0;
        bus.ram_gnt = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[0] = {2'b01, 8'd20, 7'd10};
        for (int i = 1; i < 6; i++) mem[i] = {2'b00, 8'd20, 7'(10 + i)};

        // Reset and power-up clear
        repeat (3) tick();
        reset_n = 1'b1;
        check("rst_busy", {31'd0, bus.busy}, 1);
        check("rst_plot", {31'd0, bus.vga_plot}, 0);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_oob", {31'd0, bus.oob}, 0);
        check("rst_req", {31'd0, bus.ram_req}, 0);
        check_clear();

        // Basic pass
        start_pass(11'd6, t0);
        check("p1_busy_t1", {31'd0, bus.busy}, 1);
        wait_done(40);
        check("p1_latency", done_cyc - t0, 15);
        check("p1_count", plots.size(), 6);
        check_plot("p1_head", 0, 8'd20, 7'd10, 3'b010);
        check_plot("p1_body1", 1, 8'd20, 7'd11, 3'b110);
        check_plot("p1_body5", 5, 8'd20, 7'd15, 3'b110);
        if (plots.size() > 0) check("p1_first_cyc", plots[0].cyc - t0, 5);
        check("p1_busy_after", {31'd0, bus.busy}, 0);
        check("p1_oob", {31'd0, bus.oob}, 0);

        // Second pass after moving every entry one pixel right
        for (int i = 0; i < 6; i++) mem[i][14:7] = mem[i][14:7] + 8'd1;
        start_pass(11'd6, t0);
        wait_done(40);
        check("p2_latency", done_cyc - t0, 15);
        check("p2_count", plots.size(), 7);
        check_plot("p2_erase", 0, 8'd20, 7'd15, 3'b000);
        if (plots.size() > 0) check("p2_erase_cyc", plots[0].cyc - t0, 2);
        check_plot("p2_head", 1, 8'd21, 7'd10, 3'b010);
        check_plot("p2_tail", 6, 8'd21, 7'd15, 3'b110);

        // Grant withheld for the first ten REQ cycles
        bus.ram_gnt = 1'b0;
        start_pass(11'd6, t0);
        repeat (5) tick();
        check("arb_req_held", {31'd0, bus.ram_req}, 1);
        check("arb_addr", {21'd0, bus.ram_addr}, 0);
        repeat (5) tick();
        check("arb_no_reads", plots.size(), 1);
        tick();
        bus.ram_gnt = 1'b1;
        wait_done(60);
        check("arb_latency", done_cyc - t0, 25);
        check("arb_count", plots.size(), 7);

        // Off-screen and non-drawable entries
        mem[0] = {2'b01, 8'd5, 7'd5};
        mem[1] = {2'b00, 8'd160, 7'd5};
        mem[2] = {2'b10, 8'd6, 7'd6};
        start_pass(11'd3, t0);
        wait_done(40);
        check("bnd_latency", done_cyc - t0, 9);
        check("bnd_count", plots.size(), 2);
        check_plot("bnd_erase", 0, 8'd21, 7'd15, 3'b000);
        check_plot("bnd_head", 1, 8'd5, 7'd5, 3'b010);
        check("bnd_oob", {31'd0, bus.oob}, 1);

        start_pass(11'd0, t0);
        check("len0_oob_cleared", {31'd0, bus.oob}, 0);
        wait_done(20);
        check("len0_latency", done_cyc - t0, 3);
        check("len0_no_plots", plots.size(), 0);

        mem[0] = {2'b10, 8'd6, 7'd6};
        start_pass(11'd1, t0);
        wait_done(20);
        check("type10_latency", done_cyc - t0, 5);
        check("type10_no_plots", plots.size(), 0);
        check("type10_oob", {31'd0, bus.oob}, 0);

        // Start while busy is ignored
        for (int i = 0; i < 6; i++) mem[i] = {2'b00, 8'd30, 7'(i)};
        start_pass(11'd6, t0);
        repeat (3) tick();
        bus.length = 11'd2;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        wait_done(40);
        check("ign_latency", done_cyc - t0, 15);
        check("ign_count", plots.size(), 6);
        check_plot("ign_last", 5, 8'd30, 7'd5, 3'b110);
        done_cnt = 0;
        repeat (10) tick();
        check("ign_no_extra_done", done_cnt, 0);
        check("ign_idle", {31'd0, bus.busy}, 0);

        // Reset in the middle of a pass
        start_pass(11'd6, t0);
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        check("mid_rst_req", {31'd0, bus.ram_req}, 0);
        check("mid_rst_busy", {31'd0, bus.busy}, 1);
        check("mid_rst_plot", {31'd0, bus.vga_plot}, 0);
        reset_n = 1'b1;
        check_clear();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
